// File: rtl/ra_shadow_stack_pkg.sv
// Shared definitions for the return-address shadow stack: ISA widths, the link
// key, FSM states and the link-word decoder used alongside the branch-unit encoder.
package riscv;
  localparam int unsigned VLEN = 32;
endpackage

package ariane_pkg;
  localparam logic [30:0] RA_KEY_DEFAULT = 31'h73fa06c2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } ra_state_e;

  // Inverse of the branch-unit encoding; bit 31 of the link word is always 0
  // on the wire, so the decoded address always has bit 31 set.
  function automatic logic [riscv::VLEN-1:0] ra_decode(input logic [riscv::VLEN-1:0] word,
                                                        input logic [30:0] key);
    logic [riscv::VLEN-1:0] addr;
    addr = word ^ {1'b0, key};
    addr[riscv::VLEN-1] = 1'b1;
    return addr;
  endfunction
endpackage

// File: rtl/ra_shadow_stack.sv
// Return-address shadow stack: stores decoded link addresses on calls and checks
// resolved return targets against them, raising a sticky alarm on a mismatch.
module ra_shadow_stack
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter logic [30:0] RA_KEY = RA_KEY_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic                      push_valid_i,
  input  logic [riscv::VLEN-1:0]    push_data_i,
  input  logic                      pop_valid_i,
  input  logic [riscv::VLEN-1:0]    pop_target_i,
  output logic                      mismatch_o,
  output logic                      crash_o,
  output logic [riscv::VLEN-1:0]    top_o,
  output logic [$clog2(DEPTH):0]    depth_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [7:0]                lost_o,
  output logic                      underflow_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  ra_state_e             state_reg, state_next;
  logic [riscv::VLEN-1:0] mem [DEPTH];
  logic [AW-1:0]         tp_reg, tp_next;
  logic [DW-1:0]         depth_reg, depth_next;
  logic [7:0]            lost_reg, lost_next;
  logic                  underflow_reg, underflow_next;
  logic                  mismatch_reg;

  logic                  run_act, do_push, do_pop, has_entry, is_full;
  logic                  checked_pop, pop_mismatch, mem_we;
  logic [AW-1:0]         top_idx, wr_idx;
  logic [riscv::VLEN-1:0] top_entry;

  assign run_act      = (state_reg == RUN) && en_i && !flush_i;
  assign do_push      = run_act && push_valid_i;
  assign do_pop       = run_act && pop_valid_i;
  assign has_entry    = (depth_reg != '0);
  assign is_full      = (depth_reg == DW'(DEPTH));
  assign top_idx      = tp_reg - 1'b1;
  assign top_entry    = mem[top_idx];
  assign checked_pop  = do_pop && has_entry;
  assign pop_mismatch = checked_pop && (pop_target_i != top_entry);
  // A tail call reuses the slot the pop just freed.
  assign wr_idx       = checked_pop ? top_idx : tp_reg;
  assign mem_we       = do_push && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_idx] <= ra_decode(push_data_i, RA_KEY);
    end
  end

  always_comb begin
    tp_next        = tp_reg;
    depth_next     = depth_reg;
    lost_next      = lost_reg;
    underflow_next = underflow_reg;
    if (flush_i) begin
      tp_next        = '0;
      depth_next     = '0;
      lost_next      = '0;
      underflow_next = 1'b0;
    end else begin
      if (do_pop && !has_entry) begin
        if (lost_reg != 8'd0) lost_next = lost_reg - 8'd1;
        else                  underflow_next = 1'b1;
      end
      if (do_push && !checked_pop) begin
        tp_next = tp_reg + 1'b1;
        if (is_full) begin
          // Oldest entry sits at tp_reg when full, so it is overwritten.
          if (lost_reg != 8'hff) lost_next = lost_reg + 8'd1;
        end else begin
          depth_next = depth_reg + 1'b1;
        end
      end else if (checked_pop && !do_push) begin
        tp_next    = top_idx;
        depth_next = depth_reg - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!en_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     if (pop_mismatch) state_next = ALARM;
        ALARM:   if (flush_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      tp_reg        <= '0;
      depth_reg     <= '0;
      lost_reg      <= '0;
      underflow_reg <= 1'b0;
      mismatch_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tp_reg        <= tp_next;
      depth_reg     <= depth_next;
      lost_reg      <= lost_next;
      underflow_reg <= underflow_next;
      mismatch_reg  <= pop_mismatch;
    end
  end

  assign mismatch_o  = mismatch_reg;
  assign crash_o     = (state_reg == ALARM);
  assign top_o       = has_entry ? top_entry : '0;
  assign depth_o     = depth_reg;
  assign empty_o     = !has_entry;
  assign full_o      = is_full;
  assign lost_o      = lost_reg;
  assign underflow_o = underflow_reg;
endmodule

// File: tb/tb_ra_shadow_stack.sv
// Directed bench for ra_shadow_stack: match/mismatch returns, overflow and
// underflow accounting, tail calls, flush and mid-operation reset.
module tb_ra_shadow_stack;
  logic        clk = 1'b0;
  logic        rst, en, flush, push_valid, pop_valid;
  logic [31:0] push_data, pop_target;
  logic        mismatch, crash, empty, full, underflow;
  logic [31:0] top;
  logic [4:0]  depth;
  logic [7:0]  lost;

  int n_cmp = 0;
  int n_bad = 0;

  ra_shadow_stack dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .push_valid_i(push_valid), .push_data_i(push_data),
    .pop_valid_i(pop_valid), .pop_target_i(pop_target),
    .mismatch_o(mismatch), .crash_o(crash), .top_o(top), .depth_o(depth),
    .empty_o(empty), .full_o(full), .lost_o(lost), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [31:0] a);
    logic [30:0] k;
    k = 31'h73fa06c2;
    return {1'b0, a[30:0] ^ k};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; push_valid = 0; pop_valid = 0; push_data = '0; pop_target = '0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; idle_inputs();
    cycle(); cycle();
    rst = 0;
    n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
    n_cmp++; if (lost !== 8'd0 || underflow !== 1'b0) begin n_bad++; $display("FAIL reset_lost_uf got=%0d/%b exp=0/0", lost, underflow); end
    n_cmp++; if (mismatch !== 1'b0 || crash !== 1'b0) begin n_bad++; $display("FAIL reset_alarm got=%b%b exp=00", mismatch, crash); end
    n_cmp++; if (top !== 32'h0) begin n_bad++; $display("FAIL reset_top got=%h exp=0", top); end
    $display("reset: depth=%0d empty=%b", depth, empty);
    en = 1; cycle();
  endtask

  task automatic test_match();
    push_valid = 1; push_data = 32'h73fa0ec6; cycle(); push_valid = 0;
    n_cmp++; if (depth !== 5'd1 || top !== 32'h80000804) begin n_bad++; $display("FAIL match_push got=%0d/%h exp=1/80000804", depth, top); end
    pop_valid = 1; pop_target = 32'h80000804; cycle(); pop_valid = 0;
    n_cmp++; if (mismatch !== 1'b0 || crash !== 1'b0) begin n_bad++; $display("FAIL match_pop_flags got=%b%b exp=00", mismatch, crash); end
    n_cmp++; if (depth !== 5'd0 || top !== 32'h0) begin n_bad++; $display("FAIL match_pop_depth got=%0d/%h exp=0/0", depth, top); end
    $display("match: depth=%0d mismatch=%b", depth, mismatch);
  endtask

  task automatic test_mismatch();
    push_valid = 1; push_data = 32'h73fa0ec6; cycle(); push_valid = 0;
    pop_valid = 1; pop_target = 32'h80000808; cycle(); pop_valid = 0;
    n_cmp++; if (mismatch !== 1'b1 || crash !== 1'b1) begin n_bad++; $display("FAIL mm_pulse got=%b%b exp=11", mismatch, crash); end
    n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL mm_popped got=%0d exp=0", depth); end
    cycle();
    n_cmp++; if (mismatch !== 1'b0 || crash !== 1'b1) begin n_bad++; $display("FAIL mm_sticky got=%b%b exp=01", mismatch, crash); end
    push_valid = 1; push_data = 32'h73fa0ec6; cycle(); push_valid = 0;
    n_cmp++; if (depth !== 5'd0 || crash !== 1'b1) begin n_bad++; $display("FAIL mm_push_ignored got=%0d/%b exp=0/1", depth, crash); end
    $display("mismatch: crash=%b depth=%0d", crash, depth);
  endtask

  task automatic test_flush();
    flush = 1; cycle(); flush = 0;
    n_cmp++; if (crash !== 1'b0 || depth !== 5'd0) begin n_bad++; $display("FAIL flush_clear got=%b/%0d exp=0/0", crash, depth); end
    push_valid = 1; push_data = 32'h73fa0ec6; cycle(); push_valid = 0;
    n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL flush_idle_ignores got=%0d exp=0", depth); end
    push_valid = 1; cycle(); push_valid = 0;
    n_cmp++; if (depth !== 5'd1) begin n_bad++; $display("FAIL flush_then_run got=%0d exp=1", depth); end
    flush = 1; cycle(); flush = 0;
    n_cmp++; if (depth !== 5'd0) begin n_bad++; $display("FAIL flush_run got=%0d exp=0", depth); end
    $display("flush: crash=%b depth=%0d", crash, depth);
  endtask

  task automatic test_overflow();
    logic [31:0] a;
    for (int i = 0; i < 18; i++) begin
      a = 32'h80001000 + 32'(4 * i);
      push_valid = 1; push_data = enc(a); cycle();
    end
    push_valid = 0;
    n_cmp++; if (full !== 1'b1 || depth !== 5'd16 || lost !== 8'd2) begin n_bad++; $display("FAIL ovf_state got=%b/%0d/%0d exp=1/16/2", full, depth, lost); end
    n_cmp++; if (top !== 32'h80001044) begin n_bad++; $display("FAIL ovf_top got=%h exp=80001044", top); end
    for (int k = 0; k < 16; k++) begin
      a = 32'h80001000 + 32'(4 * (17 - k));
      pop_valid = 1; pop_target = a; cycle();
      n_cmp++; if (mismatch !== 1'b0 || depth !== 5'(15 - k)) begin n_bad++; $display("FAIL ovf_pop%0d got=%b/%0d exp=0/%0d", k, mismatch, depth, 15 - k); end
    end
    pop_target = 32'h12345678;
    cycle(); cycle();
    n_cmp++; if (lost !== 8'd0 || underflow !== 1'b0 || mismatch !== 1'b0 || crash !== 1'b0) begin n_bad++; $display("FAIL ovf_lost_drain got=%0d/%b/%b/%b exp=0/0/0/0", lost, underflow, mismatch, crash); end
    cycle(); pop_valid = 0;
    n_cmp++; if (underflow !== 1'b1 || mismatch !== 1'b0) begin n_bad++; $display("FAIL ovf_underflow got=%b/%b exp=1/0", underflow, mismatch); end
    flush = 1; cycle(); flush = 0;
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL ovf_flush_uf got=%b exp=0", underflow); end
    $display("overflow: lost=%0d underflow=%b", lost, underflow);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1; push_data = enc(32'h80002000 + 32'(16 * i)); cycle();
    end
    push_valid = 0;
    n_cmp++; if (depth !== 5'd3) begin n_bad++; $display("FAIL b2b_fill got=%0d exp=3", depth); end
    push_valid = 1; push_data = enc(32'h80003abc);
    pop_valid = 1; pop_target = 32'h80002020; cycle();
    push_valid = 0; pop_valid = 0;
    n_cmp++; if (depth !== 5'd3 || top !== 32'h80003abc || mismatch !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got=%0d/%h/%b exp=3/80003abc/0", depth, top, mismatch); end
    pop_valid = 1; pop_target = 32'h80003abc; cycle(); pop_valid = 0;
    n_cmp++; if (depth !== 5'd2 || top !== 32'h80002010 || mismatch !== 1'b0) begin n_bad++; $display("FAIL b2b_after got=%0d/%h/%b exp=2/80002010/0", depth, top, mismatch); end
    $display("back_to_back: depth=%0d top=%h", depth, top);
  endtask

  task automatic test_reset_mid();
    flush = 1; cycle(); flush = 0;
    for (int i = 0; i < 5; i++) begin
      push_valid = 1; push_data = enc(32'h80004000 + 32'(4 * i)); cycle();
    end
    push_valid = 0;
    n_cmp++; if (depth !== 5'd5) begin n_bad++; $display("FAIL rmid_fill got=%0d exp=5", depth); end
    rst = 1; push_valid = 1; push_data = enc(32'h80005000); cycle();
    rst = 0; push_valid = 0;
    n_cmp++; if (depth !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || top !== 32'h0) begin n_bad++; $display("FAIL rmid_depth got=%0d/%b/%b/%h exp=0/1/0/0", depth, empty, full, top); end
    n_cmp++; if (lost !== 8'd0 || underflow !== 1'b0 || mismatch !== 1'b0 || crash !== 1'b0) begin n_bad++; $display("FAIL rmid_flags got=%0d/%b/%b/%b exp=0/0/0/0", lost, underflow, mismatch, crash); end
    $display("reset_mid: depth=%0d", depth);
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
